// File: rtl/instr_fetch_if.sv
// Instruction bus between the fetch unit (master) and instruction memory (slave).
// Signals: instr_addr_o, instr_stb_o, instr_we_o (master out); instr_data_i, instr_ack_i (slave out).
interface instr_fetch_if;
    logic [15:0] instr_addr_o;
    logic        instr_stb_o;
    logic        instr_we_o;
    logic [15:0] instr_data_i;
    logic        instr_ack_i;

    modport master (
        output instr_addr_o,
        output instr_stb_o,
        output instr_we_o,
        input  instr_data_i,
        input  instr_ack_i
    );

    modport slave (
        input  instr_addr_o,
        input  instr_stb_o,
        input  instr_we_o,
        output instr_data_i,
        output instr_ack_i
    );
endinterface

// File: rtl/instr_fetch.sv
// Sequential instruction prefetcher: stb/ack bus master feeding a flushable FIFO.
// Ports: sys_clk, sys_rst (async, active-low), redirect_i/redirect_pc_i, bus (instruction bus
// master), instr_o/instr_pc_o/instr_valid_o/instr_ready_i (decode side), bus_err_o (ack timeout).
module instr_fetch #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          PC_STEP     = 2,
    parameter int          FIFO_DEPTH  = 2,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          redirect_i,
    input  logic [15:0]   redirect_pc_i,
    instr_fetch_if.master bus,
    output logic [15:0]   instr_o,
    output logic [15:0]   instr_pc_o,
    output logic          instr_valid_o,
    input  logic          instr_ready_i,
    output logic          bus_err_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);
    localparam logic [WW-1:0] WAIT_MAX = WW'(ACK_TIMEOUT - 1);
    localparam logic [15:0]   STEP     = 16'(PC_STEP);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD,
        ABORT
    } state_t;

    state_t          r_state;
    logic            r_stb;
    logic [15:0]     r_addr;
    logic [15:0]     r_fetch_pc;
    logic [WW-1:0]   r_wait;
    logic            r_err;

    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [15:0]     r_mem_data [FIFO_DEPTH];
    logic [15:0]     r_mem_pc   [FIFO_DEPTH];

    logic            w_ack;
    logic            w_valid;
    logic            w_push;
    logic            w_pop;
    logic            w_timeout;
    logic            w_credit;
    logic [CW-1:0]   w_cnt_nxt;
    logic [15:0]     w_tgt;
    logic [15:0]     w_ack_pc;

    always_comb begin
        w_ack     = bus.instr_ack_i;
        w_valid   = (r_count != '0);
        w_push    = (r_state == REQ) && w_ack && !redirect_i;
        w_pop     = w_valid && instr_ready_i && !redirect_i;
        w_timeout = ((r_state == REQ) || (r_state == DISCARD))
                    && !w_ack && (r_wait == WAIT_MAX);
        if (redirect_i) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);
        end
        // No request is outstanding once this cycle's decision is made,
        // so a free slot after this cycle's push/pop is the whole credit.
        w_credit  = (w_cnt_nxt < DEPTH);
        // Address to (re)issue: the newest redirect target wins.
        w_tgt     = redirect_i ? redirect_pc_i : r_fetch_pc;
        w_ack_pc  = redirect_i ? redirect_pc_i : (r_fetch_pc + STEP);
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state    <= IDLE;
            r_stb      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
            r_wait     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                IDLE, ABORT: begin
                    r_fetch_pc <= w_tgt;
                    if (w_credit) begin
                        r_state <= REQ;
                        r_stb   <= 1'b1;
                        r_addr  <= w_tgt;
                        r_wait  <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                REQ: begin
                    if (w_ack) begin
                        r_fetch_pc <= w_ack_pc;
                        if (w_credit) begin
                            r_addr <= w_ack_pc;
                            r_wait <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_stb   <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_state    <= ABORT;
                        r_stb      <= 1'b0;
                        r_err      <= 1'b1;
                        r_fetch_pc <= w_tgt;
                    end else begin
                        // A live cycle is never abandoned: on redirect keep
                        // stb/addr and drop the data when it arrives.
                        r_wait     <= r_wait + WW'(1);
                        r_fetch_pc <= w_tgt;
                        if (redirect_i) begin
                            r_state <= DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    r_fetch_pc <= w_tgt;
                    if (w_ack) begin
                        if (w_credit) begin
                            r_state <= REQ;
                            r_addr  <= w_tgt;
                            r_wait  <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_stb   <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_state <= ABORT;
                        r_stb   <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_cnt_nxt;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= bus.instr_data_i;
            r_mem_pc[r_wptr]   <= r_fetch_pc;
        end
    end

    assign bus.instr_addr_o = r_addr;
    assign bus.instr_stb_o  = r_stb;
    assign bus.instr_we_o   = 1'b0;

    assign instr_valid_o = w_valid;
    assign instr_o       = w_valid ? r_mem_data[r_rptr] : 16'h0000;
    assign instr_pc_o    = w_valid ? r_mem_pc[r_rptr] : 16'h0000;
    assign bus_err_o     = r_err;
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed scenarios push expected {pc, instr}
// entries; a negedge monitor pops and compares on every valid&ready handshake.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        valid;
    logic        bus_err;

    int ack_mode = 1;
    int lat = 0;
    int stb_cnt = 0;
    int ecount = 0;
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    instr_fetch_if bus();

    instr_fetch #(
        .RESET_PC(16'h0000),
        .PC_STEP(2),
        .FIFO_DEPTH(2),
        .ACK_TIMEOUT(16)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst_n),
        .redirect_i(redirect),
        .redirect_pc_i(redirect_pc),
        .bus(bus),
        .instr_o(instr),
        .instr_pc_o(instr_pc),
        .instr_valid_o(valid),
        .instr_ready_i(ready),
        .bus_err_o(bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Memory model: mode 0 ack tied high, mode 1 never acks,
    // mode 2 acks after lat stb-high cycles.
    assign bus.instr_data_i = mem(bus.instr_addr_o);
    assign bus.instr_ack_i  = (ack_mode == 0) ||
        ((ack_mode == 2) && bus.instr_stb_o && (stb_cnt == lat));

    always @(posedge clk) begin
        if (bus.instr_stb_o && !bus.instr_ack_i) stb_cnt <= stb_cnt + 1;
        else stb_cnt <= 0;
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ex(input logic [15:0] pc);
        exp_q.push_back({pc, mem(pc)});
    endtask

    always @(negedge clk) begin
        if (rst_n && valid && ready && !redirect) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fifo_unexpected: got pc=%h instr=%h expected none",
                         instr_pc, instr);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({instr_pc, instr} !== e) begin
                    n_fail++;
                    $display("FAIL fifo_head: got pc=%h instr=%h expected pc=%h instr=%h",
                             instr_pc, instr, e[31:16], e[15:0]);
                end
            end
        end
    end

    task automatic at(input int n);
        while (ecount < n) begin
            @(posedge clk);
            ecount++;
        end
        #2;
    endtask

    task automatic do_reset(input logic rdy, input int mode, input int l);
        #1;
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        rst_n = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        ready = rdy;
        ack_mode = mode;
        lat = l;
        #1;
        chk("rst_stb", 16'(bus.instr_stb_o), 16'd0);
        chk("rst_addr", bus.instr_addr_o, 16'h0000);
        chk("rst_valid", 16'(valid), 16'd0);
        chk("rst_err", 16'(bus_err), 16'd0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_pc", instr_pc, 16'h0000);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        ecount = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        // Ack tied high, ready high: back-to-back fetch.
        do_reset(1'b1, 0, 0);
        for (int i = 0; i < 7; i++) ex(16'(2 * i));
        for (int i = 0; i < 8; i++) begin
            at(i + 1);
            @(negedge clk);
            chk("seq_stb", 16'(bus.instr_stb_o), 16'd1);
            chk("seq_addr", bus.instr_addr_o, 16'(2 * i));
            chk("seq_valid", 16'(valid), (i == 0) ? 16'd0 : 16'd1);
        end

        // Ready low: exactly two words, then one pop refetches 0004.
        do_reset(1'b0, 0, 0);
        ex(16'h0000);
        at(1); @(negedge clk);
        chk("cr_stb1", 16'(bus.instr_stb_o), 16'd1);
        chk("cr_addr1", bus.instr_addr_o, 16'h0000);
        at(2); @(negedge clk);
        chk("cr_addr2", bus.instr_addr_o, 16'h0002);
        chk("cr_pc2", instr_pc, 16'h0000);
        at(3); @(negedge clk);
        chk("cr_stb3", 16'(bus.instr_stb_o), 16'd0);
        at(4); ready = 1'b1; @(negedge clk);
        chk("cr_stb4", 16'(bus.instr_stb_o), 16'd0);
        at(5); ready = 1'b0; @(negedge clk);
        chk("cr_stb5", 16'(bus.instr_stb_o), 16'd1);
        chk("cr_addr5", bus.instr_addr_o, 16'h0004);
        chk("cr_pc5", instr_pc, 16'h0002);
        at(6); @(negedge clk);
        chk("cr_stb6", 16'(bus.instr_stb_o), 16'd0);

        // Redirect while 0006 awaits a late ack.
        do_reset(1'b1, 2, 3);
        ex(16'h0000); ex(16'h0002); ex(16'h0004); ex(16'h0100);
        at(14); redirect = 1'b1; redirect_pc = 16'h0100;
        at(15); redirect = 1'b0; @(negedge clk);
        chk("dis_stb15", 16'(bus.instr_stb_o), 16'd1);
        chk("dis_addr15", bus.instr_addr_o, 16'h0006);
        chk("dis_valid15", 16'(valid), 16'd0);
        at(16); @(negedge clk);
        chk("dis_addr16", bus.instr_addr_o, 16'h0006);
        at(17); @(negedge clk);
        chk("dis_addr17", bus.instr_addr_o, 16'h0100);
        at(21); @(negedge clk);
        chk("dis_valid21", 16'(valid), 16'd1);
        chk("dis_pc21", instr_pc, 16'h0100);

        // Redirect in the same cycle as the ack of 0008.
        do_reset(1'b1, 0, 0);
        ex(16'h0000); ex(16'h0002); ex(16'h0004); ex(16'h0200);
        at(5); redirect = 1'b1; redirect_pc = 16'h0200; @(negedge clk);
        chk("rda_addr5", bus.instr_addr_o, 16'h0008);
        at(6); redirect = 1'b0; @(negedge clk);
        chk("rda_valid6", 16'(valid), 16'd0);
        chk("rda_addr6", bus.instr_addr_o, 16'h0200);
        at(7); @(negedge clk);
        chk("rda_pc7", instr_pc, 16'h0200);

        // Ack never returns: 16 stb cycles, one error pulse, retry.
        do_reset(1'b1, 1, 0);
        for (int i = 1; i <= 16; i++) begin
            at(i); @(negedge clk);
            chk("to_stb", 16'(bus.instr_stb_o), 16'd1);
            chk("to_err_lo", 16'(bus_err), 16'd0);
        end
        at(17); @(negedge clk);
        chk("to_stb17", 16'(bus.instr_stb_o), 16'd0);
        chk("to_err17", 16'(bus_err), 16'd1);
        at(18); @(negedge clk);
        chk("to_stb18", 16'(bus.instr_stb_o), 16'd1);
        chk("to_err18", 16'(bus_err), 16'd0);
        chk("to_addr18", bus.instr_addr_o, 16'h0000);

        // Redirect in IDLE to FFFE, fetch address wraps to 0000.
        do_reset(1'b1, 0, 0);
        ex(16'hFFFE); ex(16'h0000);
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        at(1); redirect = 1'b0; @(negedge clk);
        chk("wrap_addr1", bus.instr_addr_o, 16'hFFFE);
        at(2); @(negedge clk);
        chk("wrap_addr2", bus.instr_addr_o, 16'h0000);
        at(3); @(negedge clk);

        // Reset mid-request: stb drops at once, late ack ignored.
        do_reset(1'b1, 1, 0);
        at(3);
        chk("ar_stb_pre", 16'(bus.instr_stb_o), 16'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_stb_now", 16'(bus.instr_stb_o), 16'd0);
        ack_mode = 0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        ecount = 0;
        ex(16'h0000);
        at(1); @(negedge clk);
        chk("ar_addr1", bus.instr_addr_o, 16'h0000);
        chk("ar_stb1", 16'(bus.instr_stb_o), 16'd1);
        at(2); @(negedge clk);
        chk("ar_pc2", instr_pc, 16'h0000);

        do_reset(1'b1, 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
